video_mem_port: RTL and testbench

VIDEO_MEM_PORT -- requirements
Module: video_mem_port

---
 rtl/video_mem_port.sv | 193 +++++++++++++++++++
 tb/tb_video_mem_port.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mem_port.sv
// video_mem_port: VRAM/OAM storage shared by the video fetch path, the CPU bus and OAM DMA.
module video_mem_port #(
  parameter int unsigned OAM_BYTES = 160,
  parameter logic [15:0] DMA_REG   = 16'hFF46
) (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic [12:0] rd_address_vram,
  input  logic [7:0]  rd_address_oam,
  input  logic        ld_address_vram,
  input  logic        ld_address_oam,
  input  logic        oe_vram,
  input  logic        oe_oam,
  output logic [7:0]  read_data_vram,
  output logic [7:0]  read_data_oam,
  input  logic [1:0]  mode,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] dma_src_addr,
  output logic        dma_src_rd,
  input  logic [7:0]  dma_src_data,
  output logic        dma_active
);

  localparam int unsigned VRAM_BYTES = 8192;
  localparam int unsigned OAM_AW     = (OAM_BYTES > 1) ? $clog2(OAM_BYTES) : 1;
  localparam int unsigned IDX_W      = $clog2(OAM_BYTES + 1);
  localparam logic [15:0] OAM_BASE   = 16'hFE00;
  localparam logic [15:0] OAM_END    = 16'(32'(OAM_BASE) + OAM_BYTES);
  localparam logic [15:0] ZERO_LO    = 16'hFEA0;
  localparam logic [15:0] ZERO_HI    = 16'hFEFF;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OAM_BYTES);

  typedef enum logic [1:0] {D_IDLE, D_START, D_COPY} dma_state_t;

  logic [7:0] vram [VRAM_BYTES];
  logic [7:0] oam  [OAM_BYTES];

  logic [12:0]      vram_addr_q;
  logic [7:0]       oam_addr_q;
  logic             held_q;
  logic [15:0]      held_addr_q;
  logic             held_wr_q;
  logic [7:0]       held_wdata_q;
  logic [7:0]       dma_page_q;
  logic [IDX_W-1:0] idx_q;
  dma_state_t       dma_state_q;

  logic             req_valid;
  logic [15:0]      req_addr;
  logic             req_wr;
  logic [7:0]       req_wdata;
  logic             sel_dma;
  logic             sel_vram;
  logic             sel_oam;
  logic             sel_zero;
  logic             vram_ok;
  logic             oam_ok;
  logic             conflict;
  logic             accept;
  logic             cpu_vram_we;
  logic             cpu_oam_we;
  logic             dma_start;
  logic             dma_we;
  logic [IDX_W-1:0] idx_nxt;
  logic [OAM_AW-1:0] cpu_oidx;
  logic [OAM_AW-1:0] dma_widx;
  logic [7:0]       rd_val;

  // CPU request decode: a held request takes precedence over the live bus
  always_comb begin
    req_valid   = held_q | cpu_rd | cpu_wr;
    req_addr    = held_q ? held_addr_q  : cpu_addr;
    req_wr      = held_q ? held_wr_q    : cpu_wr;
    req_wdata   = held_q ? held_wdata_q : cpu_wdata;
    sel_dma     = (req_addr == DMA_REG);
    sel_vram    = !sel_dma && (req_addr[15:13] == 3'b100);
    sel_oam     = !sel_dma && (req_addr >= OAM_BASE) && (req_addr < OAM_END);
    sel_zero    = !sel_dma && !sel_oam && (req_addr >= ZERO_LO) && (req_addr <= ZERO_HI);
    vram_ok     = (mode != 2'b11);
    oam_ok      = !mode[1] && !dma_active;
    conflict    = req_valid && ((sel_vram && vram_ok && oe_vram) || (sel_oam && oam_ok && oe_oam));
    accept      = req_valid && !conflict;
    cpu_vram_we = accept && req_wr && sel_vram && vram_ok;
    cpu_oam_we  = accept && req_wr && sel_oam && oam_ok;
    dma_start   = accept && req_wr && sel_dma;
    cpu_oidx    = OAM_AW'(req_addr[7:0]);
    dma_we      = (dma_state_q == D_COPY) && (idx_q != '0);
    dma_widx    = OAM_AW'(idx_q - IDX_W'(1));
    idx_nxt     = idx_q + IDX_W'(1);
    rd_val      = 8'hFF;
    if (sel_dma)       rd_val = dma_page_q;
    else if (sel_vram) rd_val = vram_ok ? vram[req_addr[12:0]] : 8'hFF;
    else if (sel_oam)  rd_val = oam_ok ? oam[cpu_oidx] : 8'hFF;
    else if (sel_zero) rd_val = 8'h00;
  end

  // Storage writes; contents survive reset, but a reset edge suppresses any write
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      if (cpu_vram_we) vram[req_addr[12:0]] <= req_wdata;
      if (dma_we)          oam[dma_widx] <= dma_src_data;
      else if (cpu_oam_we) oam[cpu_oidx] <= req_wdata;
    end
  end

  // Video read port: address registers and 1-cycle registered read data
  always_ff @(posedge clk_cpu) begin
    if (!rst) begin
      vram_addr_q    <= 13'h0000;
      oam_addr_q     <= 8'h00;
      read_data_vram <= 8'h00;
      read_data_oam  <= 8'h00;
    end else begin
      if (ld_address_vram) vram_addr_q <= rd_address_vram;
      if (ld_address_oam)  oam_addr_q  <= rd_address_oam;
      if (oe_vram) read_data_vram <= vram[vram_addr_q];
      if (oe_oam)  read_data_oam  <= (32'(oam_addr_q) < OAM_BYTES) ? oam[OAM_AW'(oam_addr_q)] : 8'hFF;
    end
  end

  // CPU side: ack/read data and holding a request that lost to the video port
  always_ff @(posedge clk_cpu) begin
    if (!rst) begin
      cpu_ack      <= 1'b0;
      cpu_rdata    <= 8'h00;
      held_q       <= 1'b0;
      held_addr_q  <= 16'h0000;
      held_wr_q    <= 1'b0;
      held_wdata_q <= 8'h00;
    end else begin
      cpu_ack <= accept;
      if (accept && !req_wr) cpu_rdata <= rd_val;
      held_q <= conflict;
      if (conflict) begin
        held_addr_q  <= req_addr;
        held_wr_q    <= req_wr;
        held_wdata_q <= req_wdata;
      end
    end
  end

  // OAM DMA sequencer; a page write restarts the transfer from any state
  always_ff @(posedge clk_cpu) begin
    if (!rst) begin
      dma_state_q  <= D_IDLE;
      dma_page_q   <= 8'h00;
      idx_q        <= '0;
      dma_active   <= 1'b0;
      dma_src_rd   <= 1'b0;
      dma_src_addr <= 16'h0000;
    end else if (dma_start) begin
      dma_page_q  <= req_wdata;
      dma_state_q <= D_START;
      idx_q       <= '0;
      dma_active  <= 1'b1;
      dma_src_rd  <= 1'b0;
    end else begin
      case (dma_state_q)
        D_IDLE: begin
          dma_src_rd <= 1'b0;
        end
        D_START: begin
          dma_state_q  <= D_COPY;
          idx_q        <= '0;
          dma_src_rd   <= 1'b1;
          dma_src_addr <= {dma_page_q, 8'h00};
        end
        D_COPY: begin
          if (idx_q == IDX_LAST) begin
            dma_state_q <= D_IDLE;
            dma_active  <= 1'b0;
            dma_src_rd  <= 1'b0;
          end else begin
            idx_q      <= idx_nxt;
            dma_src_rd <= (32'(idx_nxt) < OAM_BYTES);
            if (32'(idx_nxt) < OAM_BYTES) dma_src_addr <= {dma_page_q, 8'(idx_nxt)};
          end
        end
        default: begin
          dma_state_q <= D_IDLE;
          dma_active  <= 1'b0;
          dma_src_rd  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mem_port.sv
// tb_video_mem_port: randomized CPU/video/DMA traffic against a storage-level reference model.
module tb_video_mem_port;

  localparam int unsigned OAM_N = 160;

  logic        clk_cpu = 1'b0;
  logic        rst;
  logic [12:0] rd_address_vram;
  logic [7:0]  rd_address_oam;
  logic        ld_address_vram, ld_address_oam, oe_vram, oe_oam;
  logic [7:0]  read_data_vram, read_data_oam;
  logic [1:0]  mode;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [15:0] dma_src_addr;
  logic        dma_src_rd;
  logic [7:0]  dma_src_data = 8'h00;
  logic        dma_active;

  always #5 clk_cpu = ~clk_cpu;

  video_mem_port #(.OAM_BYTES(OAM_N), .DMA_REG(16'hFF46)) dut (
    .clk_cpu(clk_cpu), .rst(rst),
    .rd_address_vram(rd_address_vram), .rd_address_oam(rd_address_oam),
    .ld_address_vram(ld_address_vram), .ld_address_oam(ld_address_oam),
    .oe_vram(oe_vram), .oe_oam(oe_oam),
    .read_data_vram(read_data_vram), .read_data_oam(read_data_oam),
    .mode(mode), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_src_addr(dma_src_addr), .dma_src_rd(dma_src_rd),
    .dma_src_data(dma_src_data), .dma_active(dma_active)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  vram_m [8192];
  logic [7:0]  oam_m  [OAM_N];
  logic [7:0]  page_m;
  logic [12:0] vaddr_v;
  logic [7:0]  vaddr_o;
  logic        dma_busy_m;
  logic [7:0]  src_xor;
  logic [15:0] src_q [$];
  logic [12:0] pool [16];

  // Source memory: 1-cycle latency, byte = low address byte xor a per-test pattern
  always @(posedge clk_cpu) begin
    if (dma_src_rd) begin
      dma_src_data <= dma_src_addr[7:0] ^ src_xor;
      src_q.push_back(dma_src_addr);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic is_vram(input logic [15:0] a);
    return (a >= 16'h8000) && (a <= 16'h9FFF);
  endfunction

  function automatic logic is_oam(input logic [15:0] a);
    return (a >= 16'hFE00) && (a < 16'hFE00 + 16'(OAM_N));
  endfunction

  function automatic logic [7:0] exp_oam(input logic [7:0] a);
    return (32'(a) < OAM_N) ? oam_m[a] : 8'hFF;
  endfunction

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    if (a == 16'hFF46) return page_m;
    if (is_vram(a)) return (mode == 2'b11) ? 8'hFF : vram_m[a[12:0]];
    if (is_oam(a)) return (mode[1] || dma_busy_m) ? 8'hFF : oam_m[a[7:0]];
    if (a >= 16'hFEA0 && a <= 16'hFEFF) return 8'h00;
    return 8'hFF;
  endfunction

  task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
    if (is_vram(a) && mode != 2'b11) vram_m[a[12:0]] = d;
    else if (is_oam(a) && !mode[1] && !dma_busy_m) oam_m[a[7:0]] = d;
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  // One CPU access, optionally colliding with video reads in the request cycle
  task automatic cpu_op(input logic [15:0] a, input logic wr, input logic both,
                        input logic [7:0] wd, input logic ov, input logic oo);
    int lat;
    int exp_lat;
    logic [7:0] exp_rd, exp_vv, exp_vo;
    exp_rd  = model_rd(a);
    exp_vv  = vram_m[vaddr_v];
    exp_vo  = exp_oam(vaddr_o);
    exp_lat = ((is_vram(a) && mode != 2'b11 && ov) ||
               (is_oam(a) && !mode[1] && !dma_busy_m && oo)) ? 2 : 1;
    cpu_addr = a; cpu_wr = wr; cpu_rd = !wr || both; cpu_wdata = wd;
    oe_vram = ov; oe_oam = oo;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0; oe_vram = 1'b0; oe_oam = 1'b0;
    lat = 1;
    while (!cpu_ack && lat < 6) begin
      tick();
      lat++;
    end
    check("cpu_ack_latency", 32'(lat), 32'(exp_lat));
    if (!wr) check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, exp_rd});
    tick();
    check("cpu_ack_single_pulse", {31'h0, cpu_ack}, 32'h0);
    if (ov) check("video_vram_data", {24'h0, read_data_vram}, {24'h0, exp_vv});
    if (oo) check("video_oam_data", {24'h0, read_data_oam}, {24'h0, exp_vo});
    if (wr) model_wr(a, wd);
  endtask

  task automatic cpu_rd_chk(input logic [15:0] a);
    cpu_op(a, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic vid_ld(input logic [12:0] av, input logic [7:0] ao);
    rd_address_vram = av; rd_address_oam = ao;
    ld_address_vram = 1'b1; ld_address_oam = 1'b1;
    tick();
    ld_address_vram = 1'b0; ld_address_oam = 1'b0;
    vaddr_v = av; vaddr_o = ao;
  endtask

  task automatic vid_rd(input logic ov, input logic oo);
    logic [7:0] ev, eo;
    ev = vram_m[vaddr_v];
    eo = exp_oam(vaddr_o);
    oe_vram = ov; oe_oam = oo;
    tick();
    oe_vram = 1'b0; oe_oam = 1'b0;
    if (ov) check("video_vram_read", {24'h0, read_data_vram}, {24'h0, ev});
    if (oo) check("video_oam_read", {24'h0, read_data_oam}, {24'h0, eo});
  endtask

  task automatic dma_kick(input logic [7:0] pg);
    cpu_addr = 16'hFF46; cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_wdata = pg;
    tick();
    cpu_wr = 1'b0;
    check("dma_write_ack", {31'h0, cpu_ack}, 32'h1);
    check("dma_active_rise", {31'h0, dma_active}, 32'h1);
    check("dma_src_rd_low_in_start", {31'h0, dma_src_rd}, 32'h0);
    page_m = pg;
    dma_busy_m = 1'b1;
  endtask

  task automatic dma_wait(output int cyc);
    cyc = 0;
    while (dma_active && cyc < 400) begin
      cyc++;
      tick();
    end
    dma_busy_m = 1'b0;
  endtask

  task automatic check_sweep(input logic [7:0] pg);
    int errs;
    int base;
    errs = 0;
    base = src_q.size() - int'(OAM_N);
    if (base < 0) errs = 1;
    else for (int i = 0; i < int'(OAM_N); i++)
      if (src_q[base + i] !== {pg, 8'(i)}) errs++;
    check("dma_src_addr_sweep_errors", 32'(errs), 32'h0);
  endtask

  task automatic check_all_oam();
    for (int n = 0; n < int'(OAM_N); n++) cpu_rd_chk(16'hFE00 + 16'(n));
  endtask

  initial begin
    int cyc;
    logic [15:0] a;
    logic wr;
    rst = 1'b0; mode = 2'b00;
    rd_address_vram = '0; rd_address_oam = '0;
    ld_address_vram = 0; ld_address_oam = 0; oe_vram = 0; oe_oam = 0;
    cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0;
    src_xor = 8'h00; dma_busy_m = 1'b0; page_m = 8'h00;
    vaddr_v = '0; vaddr_o = '0;
    pool[0] = 13'h0010; pool[1] = 13'h1FFF; pool[2] = 13'h0000;
    for (int i = 3; i < 16; i++) pool[i] = 13'(i * 509);

    repeat (3) tick();
    check("reset_read_data_vram", {24'h0, read_data_vram}, 32'h0);
    check("reset_read_data_oam", {24'h0, read_data_oam}, 32'h0);
    check("reset_cpu_rdata", {24'h0, cpu_rdata}, 32'h0);
    check("reset_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    check("reset_dma_src_rd", {31'h0, dma_src_rd}, 32'h0);
    check("reset_dma_src_addr", {16'h0, dma_src_addr}, 32'h0);
    check("reset_dma_active", {31'h0, dma_active}, 32'h0);
    rst = 1'b1;
    tick();

    // VRAM write then video fetch of the same byte
    cpu_op(16'h8010, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    vid_ld(13'h0010, 8'h00);
    vid_rd(1'b1, 1'b0);
    cpu_rd_chk(16'hFF46);
    for (int i = 1; i < 16; i++)
      cpu_op(16'h8000 | {3'b000, pool[i]}, 1'b1, 1'b0, 8'(i * 37 + 1), 1'b0, 1'b0);

    // VRAM locked out in mode 11
    mode = 2'b11;
    cpu_rd_chk(16'h8010);
    cpu_op(16'h8010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    mode = 2'b00;
    cpu_rd_chk(16'h8010);

    // Address load and oe in the same cycle: oe uses the old address
    vid_ld(pool[1], 8'h00);
    rd_address_vram = pool[0]; ld_address_vram = 1'b1; oe_vram = 1'b1;
    tick();
    ld_address_vram = 1'b0; oe_vram = 1'b0;
    check("video_oe_uses_old_addr", {24'h0, read_data_vram}, {24'h0, vram_m[pool[1]]});
    vaddr_v = pool[0];
    vid_rd(1'b1, 1'b0);

    // Full DMA from page C1 with identity source data
    src_xor = 8'h00;
    src_q.delete();
    dma_kick(8'hC1);
    dma_wait(cyc);
    check("dma_active_cycles", 32'(cyc), 32'(OAM_N + 2));
    check("dma_src_rd_count", 32'(src_q.size()), 32'(OAM_N));
    check_sweep(8'hC1);
    check("dma_src_rd_low_after", {31'h0, dma_src_rd}, 32'h0);
    for (int n = 0; n < int'(OAM_N); n++) oam_m[n] = 8'(n);
    cpu_rd_chk(16'hFF46);
    check_all_oam();
    vid_ld(pool[2], 8'd7);
    vid_rd(1'b1, 1'b1);
    vid_ld(pool[2], 8'd200);
    vid_rd(1'b0, 1'b1);

    // OAM locked out in mode 10; FEA0-FEFF reads zero
    mode = 2'b10;
    cpu_op(16'hFE00, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    cpu_rd_chk(16'hFE00);
    cpu_rd_chk(16'hFEA5);
    mode = 2'b00;
    cpu_rd_chk(16'hFE00);

    // Map boundaries
    cpu_rd_chk(16'h8000); cpu_rd_chk(16'h9FFF); cpu_rd_chk(16'h7FFF);
    cpu_rd_chk(16'hA000); cpu_rd_chk(16'hFE9F); cpu_rd_chk(16'hFEA0);
    cpu_rd_chk(16'hFEFF); cpu_rd_chk(16'hFF00); cpu_rd_chk(16'hFF45);
    cpu_rd_chk(16'hFF47);
    cpu_op(16'hFEC3, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    cpu_rd_chk(16'hFEC3);

    // Same-cycle CPU and video access to the same storage
    vid_ld(pool[1], 8'd20);
    cpu_op(16'h8000 | {3'b000, pool[0]}, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cpu_op(16'hFE14, 1'b1, 1'b0, 8'hE7, 1'b0, 1'b1);
    cpu_op(16'hFE14, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 1) == 1)
        vid_ld(pool[$urandom_range(0, 15)], 8'($urandom_range(0, 255)));
      mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0, 1: a = 16'h8000 | {3'b000, pool[$urandom_range(0, 15)]};
        2: a = 16'hFE00 + 16'($urandom_range(0, OAM_N - 1));
        3: a = 16'hFEA0 + 16'($urandom_range(0, 95));
        default: a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 32'h7FFF))
                                                 : 16'($urandom_range(32'hA000, 32'hFDFF));
      endcase
      wr = 1'($urandom_range(0, 1));
      cpu_op(a, wr, 1'($urandom_range(0, 1)), 8'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    mode = 2'b00;

    // Restart: page 20 then page 40 mid-transfer; OAM blocked while DMA runs
    src_xor = 8'h3C;
    src_q.delete();
    dma_kick(8'h20);
    cpu_rd_chk(16'hFE05);
    cpu_rd_chk(16'h8000 | {3'b000, pool[0]});
    repeat (20) tick();
    dma_kick(8'h40);
    dma_wait(cyc);
    check("dma_restart_cycles", 32'(cyc), 32'(OAM_N + 2));
    check_sweep(8'h40);
    for (int n = 0; n < int'(OAM_N); n++) oam_m[n] = 8'(n) ^ 8'h3C;
    cpu_rd_chk(16'hFF46);
    check_all_oam();

    // Reset at DMA idx 50 aborts the transfer; storage survives
    src_xor = 8'h00;
    dma_kick(8'h05);
    repeat (51) tick();
    check("dma_src_addr_idx50", {16'h0, dma_src_addr}, 32'h0532);
    check("dma_src_rd_idx50", {31'h0, dma_src_rd}, 32'h1);
    rst = 1'b0;
    tick();
    check("abort_dma_active", {31'h0, dma_active}, 32'h0);
    check("abort_dma_src_rd", {31'h0, dma_src_rd}, 32'h0);
    check("abort_dma_src_addr", {16'h0, dma_src_addr}, 32'h0);
    check("abort_read_data_vram", {24'h0, read_data_vram}, 32'h0);
    rst = 1'b1;
    dma_busy_m = 1'b0; page_m = 8'h00; vaddr_v = '0; vaddr_o = '0;
    for (int n = 0; n < 49; n++) oam_m[n] = 8'(n);
    tick();
    check("post_abort_idle", {31'h0, dma_active}, 32'h0);
    cpu_rd_chk(16'hFF46);
    check_all_oam();
    for (int i = 0; i < 16; i++) cpu_rd_chk(16'h8000 | {3'b000, pool[i]});
    vid_rd(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
